// File: rtl/key_seq_pkg.sv
// Shared constants, the unlock code and the FSM state type for the key sequence detector.
package key_seq_pkg;

  localparam int SEQ_LEN = 6;
  localparam logic [2:0] SEQ [SEQ_LEN] = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd0, 3'd2};

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 270000;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 135000000;
  localparam int unsigned DEF_UNLOCK_CYCLES   = 54000000;
  localparam int unsigned DEF_ERROR_CYCLES    = 27000000;
  localparam int unsigned DEF_BLINK_CYCLES    = 3375000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Active-low progress bar: LEDs below idx are lit.
  function automatic logic [5:0] thermo_led(input logic [2:0] idx);
    logic [5:0] v;
    for (int k = 0; k < 6; k++) v[k] = (k >= int'(idx));
    return v;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-key: 2-flop synchronizer followed by a stable-level debouncer.
module key_debounce
  import key_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_key_n,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Any cycle where the synchronized value agrees with the level restarts the count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/key_sequence_detector.sv
// Six debounced push-keys feed a code-entry FSM that unlocks on 1,4,2,5,0,2.
// Handshake: press_valid is a one-cycle strobe with press_key valid in the same cycle; no back-pressure.
module key_sequence_detector
  import key_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned UNLOCK_CYCLES   = DEF_UNLOCK_CYCLES,
  parameter int unsigned ERROR_CYCLES    = DEF_ERROR_CYCLES,
  parameter int unsigned BLINK_CYCLES    = DEF_BLINK_CYCLES
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] key_n,
  output logic [5:0] led,
  output logic       unlock,
  output logic       err,
  output logic       press_valid,
  output logic [2:0] press_key,
  output logic [1:0] o_dbg_state
);

  localparam int unsigned CNT_MAX =
    (TIMEOUT_CYCLES > UNLOCK_CYCLES) ?
      ((TIMEOUT_CYCLES > ERROR_CYCLES) ? TIMEOUT_CYCLES : ERROR_CYCLES) :
      ((UNLOCK_CYCLES > ERROR_CYCLES) ? UNLOCK_CYCLES : ERROR_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   UNLOCK_LAST  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   ERROR_LAST   = CNT_W'(ERROR_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [2:0]         LAST_IDX     = 3'(SEQ_LEN - 1);

  logic [5:0] w_level;
  logic [5:0] w_fall;
  logic [2:0] w_fall_cnt;
  logic [2:0] w_fall_key;
  logic       w_wrong;
  logic       w_timeout;

  logic [5:0]         r_level_d;
  logic               r_press_valid;
  logic [2:0]         r_press_key;
  logic               r_multi;
  state_t             r_state;
  logic [2:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [BLINK_W-1:0] r_blink;
  logic [5:0]         r_led;
  logic               r_unlock;
  logic               r_err;

  for (genvar g = 0; g < 6; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_key_n   (key_n[g]),
      .o_level   (w_level[g])
    );
  end

  assign w_fall = r_level_d & ~w_level;

  always_comb begin
    w_fall_cnt = '0;
    w_fall_key = '0;
    for (int k = 0; k < 6; k++) begin
      if (w_fall[k]) begin
        w_fall_cnt = w_fall_cnt + 3'd1;
        w_fall_key = 3'(k);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_level_d     <= 6'h3F;
      r_press_valid <= 1'b0;
      r_press_key   <= '0;
      r_multi       <= 1'b0;
    end else begin
      r_level_d     <= w_level;
      r_press_valid <= (w_fall_cnt == 3'd1);
      r_multi       <= (w_fall_cnt > 3'd1);
      if (w_fall_cnt == 3'd1) r_press_key <= w_fall_key;
    end
  end

  // In IDLE r_idx is 0, so the same wrong-key test covers both IDLE and ENTRY.
  assign w_wrong   = r_multi || (r_press_valid && (r_press_key != SEQ[r_idx]));
  assign w_timeout = (r_state == ST_ENTRY) && !r_press_valid && (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_blink  <= '0;
      r_led    <= 6'h3F;
      r_unlock <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ENTRY: begin
          if (w_wrong || w_timeout) begin
            r_state <= ST_ERROR;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_blink <= '0;
            r_led   <= 6'h00;
            r_err   <= 1'b1;
          end else if (r_press_valid) begin
            if (r_idx == LAST_IDX) begin
              r_state  <= ST_UNLOCKED;
              r_idx    <= '0;
              r_cnt    <= '0;
              r_led    <= 6'h00;
              r_unlock <= 1'b1;
            end else begin
              r_state <= ST_ENTRY;
              r_idx   <= r_idx + 3'd1;
              r_cnt   <= '0;
              r_led   <= thermo_led(r_idx + 3'd1);
            end
          end else if (r_state == ST_ENTRY) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_UNLOCKED: begin
          if (r_cnt == UNLOCK_LAST) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_led    <= 6'h3F;
            r_unlock <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ERROR: begin
          if (r_cnt == ERROR_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_blink <= '0;
            r_led   <= 6'h3F;
            r_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_blink == BLINK_LAST) begin
              r_blink <= '0;
              r_led   <= ~r_led;
            end else begin
              r_blink <= r_blink + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign led         = r_led;
  assign unlock      = r_unlock;
  assign err         = r_err;
  assign press_valid = r_press_valid;
  assign press_key   = r_press_key;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_sequence_detector.sv
// Directed and randomized bench for key_sequence_detector with a press-level reference model.
module tb_key_sequence_detector;

  localparam int DEB  = 4;
  localparam int TO   = 200;
  localparam int UNL  = 50;
  localparam int ERRC = 30;
  localparam int BLK  = 5;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [5:0] key_n;
  logic [5:0] led;
  logic       unlock;
  logic       err;
  logic       press_valid;
  logic [2:0] press_key;
  logic [1:0] dbg_state;

  key_sequence_detector #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TO),
    .UNLOCK_CYCLES   (UNL),
    .ERROR_CYCLES    (ERRC),
    .BLINK_CYCLES    (BLK)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_n       (key_n),
    .led         (led),
    .unlock      (unlock),
    .err         (err),
    .press_valid (press_valid),
    .press_key   (press_key),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  int seq_ref[6] = '{1, 4, 2, 5, 0, 2};
  int m_state = 0;  // 0 idle, 1 entry, 2 unlocked, 3 error
  int m_prog  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and output monitors, sampled on the falling edge
  int pv_count = 0;
  int unl_run = 0, unl_last = 0, unl_led_bad = 0;
  int err_run = 0, err_last = 0, err_toggles = 0, blink_run = 0, blink_bad = 0;
  logic [5:0] err_first_led = 6'h3F;
  logic       err_prev = 1'b0;
  logic [5:0] led_prev = 6'h3F;

  always @(negedge sys_clk) begin
    if (sys_rst_n && press_valid) begin
      pv_count++;
      check("press_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("press_key", 32'(press_key), 32'(exp_q.pop_front()));
    end
    if (unlock) begin
      unl_run++;
      if (led != 6'h00) unl_led_bad++;
    end else if (unl_run > 0) begin
      unl_last = unl_run;
      unl_run  = 0;
    end
    if (err) begin
      if (led != 6'h00 && led != 6'h3F) blink_bad++;
      if (!err_prev) begin
        err_first_led = led;
        err_toggles   = 0;
        blink_run     = 1;
        blink_bad     = 0;
      end else if (led != led_prev) begin
        if (blink_run != BLK) blink_bad++;
        blink_run = 1;
        err_toggles++;
      end else begin
        blink_run++;
      end
      err_run++;
    end else if (err_prev) begin
      if (blink_run != BLK) blink_bad++;
      err_last = err_run;
      err_run  = 0;
    end
    err_prev = err;
    led_prev = led;
  end

  // Reference model: press-level rules of the code lock
  function automatic void model_press(input int key, input bit multi);
    if (m_state >= 2) return;
    if (multi || key != seq_ref[m_prog]) begin
      m_state = 3;
      m_prog  = 0;
    end else if (m_prog == 5) begin
      m_state = 2;
      m_prog  = 0;
    end else begin
      m_state = 1;
      m_prog++;
    end
  endfunction

  function automatic logic [5:0] model_led();
    logic [5:0] v;
    case (m_state)
      0:       v = 6'h3F;
      1:       v = 6'(6'h3F << m_prog);
      default: v = 6'h00;
    endcase
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    if (m_state != 3) check({tag, "_led"}, 32'(led), 32'(model_led()));
    check({tag, "_unlock"}, 32'(unlock), 32'(m_state == 2));
    check({tag, "_err"}, 32'(err), 32'(m_state == 3));
    check({tag, "_state"}, 32'(dbg_state), 32'(m_state));
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic press_keys(input logic [5:0] mask, input int hold, input int gap);
    int key;
    key = 0;
    for (int k = 0; k < 6; k++) if (mask[k]) key = k;
    if ($countones(mask) == 1) begin
      exp_q.push_back(3'(key));
      model_press(key, 1'b0);
    end else begin
      model_press(0, 1'b1);
    end
    key_n = ~mask;
    tick(hold);
    key_n = 6'h3F;
    tick(gap);
  endtask

  task automatic press(input int key);
    press_keys(6'(1 << key), 10, 10);
  endtask

  initial begin : stim
    int pv_before;
    int key;
    key_n     = 6'h3F;
    sys_rst_n = 1'b0;
    tick(3);
    check("rst_led", 32'(led), 32'h3F);
    check("rst_unlock", 32'(unlock), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_press_valid", 32'(press_valid), 32'd0);
    check("rst_press_key", 32'(press_key), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    sys_rst_n = 1'b1;
    tick(20);
    check("no_spurious_press", 32'(pv_count), 32'd0);

    // Full correct code
    for (int i = 0; i < 6; i++) begin
      press(seq_ref[i]);
      check_outputs($sformatf("seq_step%0d", i));
    end
    tick(60);
    check("unlock_len", 32'(unl_last), 32'(UNL));
    check("unlock_led_dark", 32'(unl_led_bad), 32'd0);
    m_state = 0;
    check_outputs("after_unlock");

    // Bouncing key 1 then stable hold
    pv_before = pv_count;
    exp_q.push_back(3'd1);
    model_press(1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      key_n[1] = 1'b0;
      tick(2);
      key_n[1] = 1'b1;
      tick(2);
    end
    key_n[1] = 1'b0;
    tick(12);
    key_n[1] = 1'b1;
    tick(12);
    check("bounce_one_press", 32'(pv_count - pv_before), 32'd1);
    check_outputs("bounce_entry");

    // 1,4,3 -> error with blinking
    press(4);
    check_outputs("wrong_prefix");
    press(3);
    check_outputs("wrong_key");
    tick(30);
    check("err_len", 32'(err_last), 32'(ERRC));
    check("err_first_led", 32'(err_first_led), 32'h00);
    check("err_toggles", 32'(err_toggles), 32'(ERRC / BLK - 1));
    check("blink_period", 32'(blink_bad), 32'd0);
    m_state = 0;
    check_outputs("err_done");

    // Entry timeout
    press(1);
    tick(150);
    check("timeout_early_err", 32'(err), 32'd0);
    check("timeout_early_state", 32'(dbg_state), 32'd1);
    tick(60);
    check("timeout_err", 32'(err), 32'd1);
    m_state = 3;
    m_prog  = 0;
    tick(40);
    m_state = 0;
    check_outputs("timeout_done");

    // Two keys debounced together
    pv_before = pv_count;
    press_keys(6'b100100, 10, 10);
    check("multi_no_press", 32'(pv_count - pv_before), 32'd0);
    check_outputs("multi_err");
    tick(40);
    m_state = 0;
    check_outputs("multi_done");

    // Presses during ERROR are reported but ignored
    press(0);
    check_outputs("idle_wrong");
    press(1);
    check("ignored_state", 32'(dbg_state), 32'd0);
    check("ignored_led", 32'(led), 32'h3F);
    check("ignored_err", 32'(err), 32'd0);
    m_state = 0;

    // Reset mid-entry
    press(1);
    press(4);
    press(2);
    check_outputs("pre_reset");
    sys_rst_n = 1'b0;
    #1;
    check("mid_reset_led", 32'(led), 32'h3F);
    check("mid_reset_state", 32'(dbg_state), 32'd0);
    m_state = 0;
    m_prog  = 0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(5);
    for (int i = 0; i < 6; i++) press(seq_ref[i]);
    check_outputs("post_reset_unlock");
    tick(60);
    m_state = 0;
    check_outputs("post_reset_idle");

    // Randomized presses, biased toward the correct next key
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) key = int'($urandom_range(0, 5));
      else key = seq_ref[m_prog];
      press_keys(6'(1 << key), int'($urandom_range(6, 14)), int'($urandom_range(8, 14)));
      check_outputs($sformatf("rand%0d", it));
      if (m_state >= 2) begin
        tick(60);
        m_state = 0;
        check_outputs($sformatf("rand%0d_idle", it));
      end
    end

    tick(10);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_sequence_detector.md
KEY_SEQUENCE_DETECTOR -- requirements
Module: key_sequence_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000, SHALL set the stable-input cycles needed to accept a key level (10 ms at 27 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 135000000, SHALL set the idle gap that aborts an entry (5 s).
REQ-003 Parameter UNLOCK_CYCLES, default 54000000, SHALL set the hold time of the UNLOCKED state (2 s).
REQ-004 Parameter ERROR_CYCLES, default 27000000, SHALL set the hold time of the ERROR state (1 s).
REQ-005 Parameter BLINK_CYCLES, default 3375000, SHALL set the LED toggle half-period in ERROR.
REQ-006 sys_clk  input  1  clock; all logic SHALL run on its rising edge.
REQ-007 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 key_n  input  6  asynchronous push-keys, active-low (0 = pressed); bit i is key i.
REQ-009 led  output 6  active-low LEDs (0 = lit).
REQ-010 unlock  output 1  high while in UNLOCKED.
REQ-011 err  output 1  high while in ERROR.
REQ-012 press_valid  output 1  one-cycle pulse per accepted single-key press.
REQ-013 press_key  output 3  index 0..5 of the key reported with press_valid; holds its last value otherwise.

Function
REQ-014 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each bit SHALL change its debounced level only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-016 A press event SHALL be a debounced 1->0 transition; releases SHALL produce no event.
REQ-017 press_valid SHALL assert the cycle after the debounced transition, with press_key = key index.
REQ-018 If two or more keys produce press events in the same cycle, press_valid SHALL stay low and the event SHALL count as a wrong key.
REQ-019 The expected code SHALL be SEQ = 1,4,2,5,0,2 (SEQ_LEN = 6), held in a progress index idx (0..5).
REQ-020 FSM states SHALL be IDLE, ENTRY, UNLOCKED and ERROR.
REQ-021 IDLE, correct key SEQ[0]: go to ENTRY with idx = 1. Wrong key or multi-key: go to ERROR.
REQ-022 ENTRY, key == SEQ[idx] and idx < 5: idx increments and the timeout counter clears.
REQ-023 ENTRY, key == SEQ[5] at idx = 5: go to UNLOCKED with idx = 0.
REQ-024 ENTRY, wrong key or multi-key: go to ERROR with idx = 0.
REQ-025 ENTRY with no event for TIMEOUT_CYCLES cycles: go to ERROR.
REQ-026 UNLOCKED and ERROR SHALL ignore all events (press_valid still pulses) and return to IDLE after UNLOCK_CYCLES or ERROR_CYCLES.
REQ-027 The state transition SHALL occur on the edge after press_valid is high, so the state is visible 1 cycle after the pulse.
REQ-028 LEDs: IDLE 6'b111111; ENTRY led[k] = 0 for k < idx (thermometer); UNLOCKED 6'b000000.
REQ-029 LEDs in ERROR: all six toggle together every BLINK_CYCLES, starting lit (6'b000000) on entry.
REQ-030 unlock, err and led SHALL be registered outputs decoded from the state.

Reset
REQ-031 Reset assertion SHALL immediately force: state IDLE, idx 0, all counters 0, led 6'b111111, unlock 0, err 0, press_valid 0, press_key 0.
REQ-032 Reset SHALL set synchronizer and debounced levels to 1 (released), so a key held through reset produces no press on release of reset.
REQ-033 Reset mid-entry SHALL discard all progress; deassertion SHALL be followed by normal operation from IDLE.

Structure
REQ-034 Package key_seq_pkg SHALL hold SEQ_LEN, the SEQ constant array (3-bit entries), the state typedef, and the default cycle constants.
REQ-035 Per-key synchronization and debouncing SHALL be a sub-module key_debounce (1 bit, DEBOUNCE_CYCLES parameter), instantiated 6 times.
REQ-036 Counters SHALL be sized by $clog2 of their parameter; 28 bits SHALL suffice for the defaults.

Verification (DEBOUNCE=4, TIMEOUT=200, UNLOCK=50, ERROR=30, BLINK=5)
REQ-037 Press keys 1,4,2,5,0,2, each held 10 cycles with gaps of 10 cycles -> led steps 111110, 111100, 111000, 110000, 100000, then unlock = 1 and led 000000 for 50 cycles, then IDLE.
REQ-038 Key 1 bouncing at 2-cycle intervals, then held stable -> exactly one press_valid, with press_key = 1.
REQ-039 Sequence 1,4,3 -> err = 1 after the third press; led blinks 000000/111111 every 5 cycles; IDLE after 30 cycles.
REQ-040 Press key 1, then nothing for 200 cycles -> ERROR.
REQ-041 Keys 2 and 5 debounced in the same cycle -> no press_valid, ERROR.
REQ-042 Assert reset at idx = 3 -> led 111111 and state IDLE immediately; a correct full sequence afterwards -> unlock.
